// File: rtl/can_error_frame_tx_pkg.sv
// Shared CAN error-signalling definitions: FSM state encodings, bus levels and default frame lengths.
package can_error_frame_tx_pkg;

    localparam int FLAG_LEN_DEF  = 6;
    localparam int DELIM_LEN_DEF = 8;
    localparam int EXT_DOM_DEF   = 14;
    localparam int EXT_REP_DEF   = 8;

    localparam logic BUS_DOM = 1'b0;
    localparam logic BUS_REC = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_FLAG       = 2'd1,
        S_WAIT_DELIM = 2'd2,
        S_DELIM      = 2'd3
    } state_t;

    // True when dom_nxt is first, first+rep, first+2*rep, ...
    function automatic logic ext_dom_hit(input logic [7:0] dom_nxt, input int first, input int rep);
        logic [7:0] diff;
        diff = dom_nxt - 8'(first);
        return (dom_nxt >= 8'(first)) && ((diff % 8'(rep)) == 8'd0);
    endfunction

endpackage

// File: rtl/can_sat_counter.sv
// Saturating up-counter with synchronous clear and load; clear wins over load, load over increment.
module can_sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/can_error_frame_tx.sv
// CAN error-frame transmitter: serialises error flag and delimiter, reports completion and bus faults.
// Optional frame/abort statistics outputs are enabled with `define CAN_ERRTX_STATS_EN.
//
// state      | meaning
// IDLE       | no error frame, tx recessive
// FLAG       | sending error flag (dominant if active, recessive if passive)
// WAIT_DELIM | flag done, waiting for first recessive bit, watching extended dominant
// DELIM      | counting recessive delimiter bits
module can_error_frame_tx
    import can_error_frame_tx_pkg::*;
#(
    parameter int FLAG_LEN  = FLAG_LEN_DEF,
    parameter int DELIM_LEN = DELIM_LEN_DEF,
    parameter int EXT_DOM   = EXT_DOM_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_tick,
    input  logic        rx_bit,
    input  logic        error_frame_req,
    input  logic        error_passive,
    input  logic        bus_off,
    output logic        tx_bit,
    output logic        busy,
    output logic        error_frame_sent,
    output logic        ext_dom_err,
    output logic        delim_form_err
`ifdef CAN_ERRTX_STATS_EN
    ,
    output logic [15:0] err_frame_cnt,
    output logic [7:0]  abort_cnt
`endif
);

    state_t     state;
    logic       req_q;
    logic       passive_q;
    logic       prev_rx;
    logic [3:0] bit_cnt;
    logic [3:0] eq_cnt;
    logic [7:0] dom_cnt;

    logic       start;
    logic       tick_flag;
    logic       eq_restart;
    logic [3:0] eq_nxt;
    logic       flag_done;
    logic       delim_enter;
    logic       dom_tick;
    logic       ext_hit;
    logic       delim_rec;
    logic       delim_done;
    logic       delim_err;
    logic       cnt_clr;
    logic       bit_inc;
    logic       eq_ld;
    logic       eq_inc;

    always_comb begin
        start       = (state == S_IDLE) && error_frame_req && !req_q && !bus_off;
        tick_flag   = (state == S_FLAG) && bit_tick;
        eq_restart  = (eq_cnt != 4'd0) && (rx_bit != prev_rx);
        eq_nxt      = eq_restart ? 4'd1 : eq_cnt + 4'd1;
        flag_done   = tick_flag && (passive_q ? (eq_nxt == 4'(FLAG_LEN))
                                              : (bit_cnt == 4'(FLAG_LEN - 1)));
        delim_enter = (state == S_WAIT_DELIM) && bit_tick && (rx_bit == BUS_REC);
        dom_tick    = (state == S_WAIT_DELIM) && bit_tick && (rx_bit == BUS_DOM);
        ext_hit     = dom_tick && (dom_cnt != 8'hFF)
                      && ext_dom_hit(dom_cnt + 8'd1, EXT_DOM, EXT_REP_DEF);
        delim_rec   = (state == S_DELIM) && bit_tick && (rx_bit == BUS_REC);
        delim_done  = delim_rec && (bit_cnt == 4'(DELIM_LEN - 1));
        delim_err   = (state == S_DELIM) && bit_tick && (rx_bit == BUS_DOM);
        // Any frame boundary or abort leaves every counter at zero for the next phase.
        cnt_clr     = bus_off || start || flag_done || delim_done || delim_err;
        bit_inc     = (tick_flag && !passive_q) || delim_rec;
        eq_ld       = tick_flag && passive_q && eq_restart;
        eq_inc      = tick_flag && passive_q;
    end

    can_sat_counter #(.WIDTH(4)) u_bit_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .ld     (delim_enter),
        .ld_val (4'd1),
        .inc    (bit_inc),
        .cnt    (bit_cnt)
    );

    can_sat_counter #(.WIDTH(4)) u_eq_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .ld     (eq_ld),
        .ld_val (4'd1),
        .inc    (eq_inc),
        .cnt    (eq_cnt)
    );

    can_sat_counter #(.WIDTH(8)) u_dom_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .ld     (1'b0),
        .ld_val (8'd0),
        .inc    (dom_tick),
        .cnt    (dom_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            tx_bit           <= BUS_REC;
            busy             <= 1'b0;
            error_frame_sent <= 1'b0;
            ext_dom_err      <= 1'b0;
            delim_form_err   <= 1'b0;
            req_q            <= 1'b0;
            passive_q        <= 1'b0;
            prev_rx          <= BUS_REC;
        end else begin
            req_q            <= error_frame_req;
            error_frame_sent <= 1'b0;
            ext_dom_err      <= 1'b0;
            delim_form_err   <= 1'b0;
            tx_bit           <= ((state == S_FLAG) && !passive_q) ? BUS_DOM : BUS_REC;
            if (bus_off) begin
                state  <= S_IDLE;
                busy   <= 1'b0;
                tx_bit <= BUS_REC;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state     <= S_FLAG;
                            busy      <= 1'b1;
                            passive_q <= error_passive;
                        end
                    end
                    S_FLAG: begin
                        if (bit_tick) prev_rx <= rx_bit;
                        if (flag_done) state <= S_WAIT_DELIM;
                    end
                    S_WAIT_DELIM: begin
                        ext_dom_err <= ext_hit;
                        if (delim_enter) state <= S_DELIM;
                    end
                    S_DELIM: begin
                        if (delim_done) begin
                            state            <= S_IDLE;
                            busy             <= 1'b0;
                            error_frame_sent <= 1'b1;
                        end else if (delim_err) begin
                            state          <= S_FLAG;
                            delim_form_err <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef CAN_ERRTX_STATS_EN
    logic frame_inc;
    logic abort_inc;

    always_comb begin
        frame_inc = delim_done && !bus_off;
        abort_inc = (delim_err && !bus_off) || (bus_off && (state != S_IDLE));
    end

    can_sat_counter #(.WIDTH(16)) u_frame_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .ld     (1'b0),
        .ld_val (16'd0),
        .inc    (frame_inc),
        .cnt    (err_frame_cnt)
    );

    can_sat_counter #(.WIDTH(8)) u_abort_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .ld     (1'b0),
        .ld_val (8'd0),
        .inc    (abort_inc),
        .cnt    (abort_cnt)
    );
`endif

endmodule
